cpu_div_unit: RTL and testbench
===============================

# cpu_div_unit

Multi-cycle integer divide/remainder unit in the CPU execute stage, directly upstream of the register file. It accepts one operation from issue and computes it with a radix-2 restoring iteration. It then drives the register file's priority write port (rd1) for exactly one cycle. While an operation is in flight it also exports the destination register so issue can stall dependent reads.

## Interface
- REG_COUNT, 16, number of architectural registers; register 0 is hard-wired zero
- REG_WIDTH, 16, operand/result width in bits
- ADDR_WIDTH, $clog2(REG_COUNT), derived localparam; not overridable

Reset is asynchronous and active-low; one clock.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE with flush low
- op  in  2  00 DIVU, 01 DIV, 10 REMU, 11 REM
- dividend  in  REG_WIDTH  rs1 value, sampled on acceptance
- divisor  in  REG_WIDTH  rs2 value, sampled on acceptance
- rd  in  ADDR_WIDTH  destination, sampled on acceptance
- flush  in  1  kill any in-flight operation; no writeback
- busy  out  1  high in every non-IDLE state
- pending_valid  out  1  busy && latched rd != 0
- pending_rd  out  ADDR_WIDTH  latched destination; 0 when idle
- rd1  out  ADDR_WIDTH  writeback register; 0 unless writing
- rd1_write_enable  out  1  one-cycle writeback strobe
- rd1_write_data  out  REG_WIDTH  result; 0 unless writing

## Operation
- States:
  - IDLE
  - CALC: REG_WIDTH cycles, one quotient bit per cycle
  - FIX: sign correction and special-case select
  - WB: writeback
- Transitions:
  - IDLE→CALC on start && !flush.
  - CALC→FIX when iteration counter reaches REG_WIDTH-1.
  - FIX→WB.
  - WB→IDLE.
  - Any state→IDLE on flush.
- Signed ops (DIV/REM):
  - Operands converted to magnitudes on acceptance; sign flags latched.
  - Quotient negated if operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
- Unsigned ops use operands as-is.
- Iteration: partial remainder is REG_WIDTH+1 bits wide, so no overflow; iteration counter is $clog2(REG_WIDTH)+1 bits.
- Divide by zero, all ops: quotient = all ones; remainder = dividend (original, unconverted).
- Signed overflow (dividend = 1 followed by zeros, divisor = all ones, DIV/REM): quotient = dividend; remainder = 0.
- Special cases still take the full fixed latency; the result is selected in FIX.
- rd = 0: operation runs normally, but rd1_write_enable stays 0 in WB.
- start while busy: ignored. No queueing, no error.
- start and flush in the same cycle: start ignored.
- Operand inputs are only sampled on acceptance; changes afterwards have no effect.

## Timing
- Reset: state IDLE.
  - All outputs 0: busy, pending_valid, pending_rd, rd1, rd1_write_enable, rd1_write_data.
  - Internal datapath registers cleared.
- Latency, with start accepted at the edge ending cycle 0:
  - CALC in cycles 1..REG_WIDTH.
  - FIX in cycle REG_WIDTH+1.
  - WB in cycle REG_WIDTH+2 (cycle 18 for default REG_WIDTH = 16).
- Writeback outputs are registered:
  - rd1, rd1_write_data and rd1_write_enable are valid during the WB cycle only.
  - They are 0 in every other cycle.
- busy is high in cycles 1..REG_WIDTH+2 and low in cycle REG_WIDTH+3.
  - The next start can be accepted in that cycle.
  - Throughput is one operation per REG_WIDTH+3 cycles.
- pending_valid and pending_rd track busy exactly, including the WB cycle.
  - The register file's rd1 bypass is not relied upon for this unit.
- flush asserted in cycle k (any non-IDLE state, including WB):
  - IDLE from cycle k+1; busy is low in cycle k+1.
  - If k is the WB cycle, the registered strobe is already out and that write completes.
  - A flush in CALC or FIX never produces a write.
- rst_n deasserted mid-operation: immediate return to the reset values; no write issued afterwards.

## Test plan
- DIVU 100/7, rd=3 at cycle 0:
  - Cycle 18: rd1=3, rd1_write_data=14, rd1_write_enable=1.
  - busy high cycles 1..18; pending_rd=3 throughout.
- REM 0xFFF9 (-7) / 2, rd=5: cycle 18 data 0xFFFF (-1). DIV of the same operands: 0xFFFD (-3).
- Divide by zero:
  - DIVU 5/0 → 0xFFFF.
  - REMU 5/0 → 0x0005.
  - DIV 0x8000/0 → 0xFFFF.
- Signed overflow:
  - DIV 0x8000/0xFFFF → 0x8000.
  - REM 0x8000/0xFFFF → 0x0000.
- Control:
  - flush in cycle 5 → busy low in cycle 6, no write ever.
  - New start in cycle 6 → write at cycle 24.
  - start held during cycles 1..18 → exactly one write.
  - rd=0 op → busy cycles 1..18, no write strobe.
- rst_n low in cycle 10 → all outputs 0 immediately; no write follows. Restart after release completes normally.

Source files
------------

// File: rtl/cpu_div_unit.sv
// rtl/cpu_div_unit.sv - radix-2 restoring divide/remainder unit with one-cycle register-file writeback
module cpu_div_unit #(
  parameter int REG_COUNT = 16,
  parameter int REG_WIDTH = 16,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [REG_WIDTH-1:0]  dividend,
  input  logic [REG_WIDTH-1:0]  divisor,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  flush,
  output logic                  busy,
  output logic                  pending_valid,
  output logic [ADDR_WIDTH-1:0] pending_rd,
  output logic [ADDR_WIDTH-1:0] rd1,
  output logic                  rd1_write_enable,
  output logic [REG_WIDTH-1:0]  rd1_write_data
);

  localparam int CNT_WIDTH = $clog2(REG_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(REG_WIDTH - 1);
  localparam logic [REG_WIDTH-1:0] MIN_NEG = {1'b1, {(REG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;
  state_t state, state_next;

  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [REG_WIDTH-1:0]  dividend_q, divisor_q, divisor_mag_q;
  logic [REG_WIDTH-1:0]  quo_q, rem_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  neg_quo_q, neg_rem_q;

  logic                  accept;
  logic                  dividend_neg, divisor_neg;
  logic [REG_WIDTH:0]    part_rem;
  logic                  fits;
  logic                  div_zero, overflow;
  logic [REG_WIDTH-1:0]  quotient, remainder, result;

  assign accept       = (state == IDLE) && start && !flush;
  assign dividend_neg = op[0] && dividend[REG_WIDTH-1];
  assign divisor_neg  = op[0] && divisor[REG_WIDTH-1];

  // Shifted partial remainder keeps one extra bit so the trial subtract never overflows.
  assign part_rem = {rem_q, quo_q[REG_WIDTH-1]};
  assign fits     = part_rem >= {1'b0, divisor_mag_q};

  assign div_zero = (divisor_q == '0);
  assign overflow = op_q[0] && (dividend_q == MIN_NEG) && (divisor_q == '1);

  always_comb begin
    quotient  = neg_quo_q ? -quo_q : quo_q;
    remainder = neg_rem_q ? -rem_q : rem_q;
    if (div_zero) begin
      quotient  = '1;
      remainder = dividend_q;
    end else if (overflow) begin
      quotient  = dividend_q;
      remainder = '0;
    end
    result = op_q[1] ? remainder : quotient;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt_q == LAST_ITER) state_next = FIX;
      FIX:     state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      rd_q          <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      divisor_mag_q <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
    end else if (accept) begin
      op_q          <= op;
      rd_q          <= rd;
      dividend_q    <= dividend;
      divisor_q     <= divisor;
      divisor_mag_q <= divisor_neg ? -divisor : divisor;
      quo_q         <= dividend_neg ? -dividend : dividend;
      rem_q         <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= dividend_neg ^ divisor_neg;
      neg_rem_q     <= dividend_neg;
    end else if (state == CALC) begin
      rem_q <= fits ? REG_WIDTH'(part_rem - {1'b0, divisor_mag_q}) : part_rem[REG_WIDTH-1:0];
      quo_q <= {quo_q[REG_WIDTH-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Writeback is loaded on the FIX->WB edge so the strobe is a clean registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1              <= '0;
      rd1_write_enable <= 1'b0;
      rd1_write_data   <= '0;
    end else if ((state == FIX) && !flush && (rd_q != '0)) begin
      rd1              <= rd_q;
      rd1_write_enable <= 1'b1;
      rd1_write_data   <= result;
    end else begin
      rd1              <= '0;
      rd1_write_enable <= 1'b0;
      rd1_write_data   <= '0;
    end
  end

  assign busy          = (state != IDLE);
  assign pending_valid = busy && (rd_q != '0);
  assign pending_rd    = busy ? rd_q : '0;

endmodule

// File: tb/tb_cpu_div_unit.sv
// tb/tb_cpu_div_unit.sv - vector table plus control sequences for cpu_div_unit, scoreboarded writebacks
module tb_cpu_div_unit;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int WB_CYCLE = W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  dividend, divisor;
  logic [AW-1:0] rd;
  logic          flush;
  logic          busy, pending_valid;
  logic [AW-1:0] pending_rd, rd1;
  logic          rd1_write_enable;
  logic [W-1:0]  rd1_write_data;

  always #5 clk = ~clk;

  cpu_div_unit #(.REG_COUNT(16), .REG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .rd(rd), .flush(flush),
    .busy(busy), .pending_valid(pending_valid), .pending_rd(pending_rd),
    .rd1(rd1), .rd1_write_enable(rd1_write_enable), .rd1_write_data(rd1_write_data)
  );

  typedef struct packed {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } wb_t;

  wb_t  exp_q[$];
  wb_t  mon_e;
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    logic ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ovf = (a == 16'h8000) && (b == 16'hFFFF);
    case (o)
      2'b00:   return (b == 0) ? 16'hFFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      2'b01:   return (b == 0) ? 16'hFFFF : (ovf ? 16'h8000 : 16'(sa / sb));
      default: return (b == 0) ? a : (ovf ? 16'h0000 : 16'(sa % sb));
    endcase
  endfunction

  // Scoreboard: every strobe must match the oldest expectation; quiet cycles must be all-zero.
  always @(negedge clk) begin
    if (rd1_write_enable) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("wb_rd", 32'(rd1), 32'(mon_e.rd));
        check("wb_data", 32'(rd1_write_data), 32'(mon_e.data));
      end
    end else begin
      check("quiet_wb_zero", 32'({rd1, rd1_write_data}), 32'd0);
    end
  end

  // Called on a negedge with the unit idle; that cycle is cycle 0.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] r, input logic [W-1:0] e,
                        input int flush_at, input bit hold);
    int   wr0;
    wb_t  item;
    wr0 = n_writes;
    op = o; dividend = a; divisor = b; rd = r; start = 1'b1;
    if (r != 0 && (flush_at == 0 || flush_at >= WB_CYCLE)) begin
      item.rd = r; item.data = e;
      exp_q.push_back(item);
    end
    @(posedge clk);
    for (int c = 1; c <= WB_CYCLE; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = hold; dividend = ~a; divisor = b + 16'd1; rd = r + 4'd1;
      end
      check("busy", 32'(busy), 32'd1);
      check("pending_valid", 32'(pending_valid), 32'(r != 0));
      check("pending_rd", 32'(pending_rd), 32'(r));
      if (c < WB_CYCLE) check("no_early_strobe", 32'(rd1_write_enable), 32'd0);
      else              check("wb_strobe", 32'(rd1_write_enable), 32'(r != 0));
      if (c == flush_at) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_pending_rd", 32'(pending_rd), 32'd0);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_busy", 32'(busy), 32'd0);
    check("done_pending_valid", 32'(pending_valid), 32'd0);
    check("done_pending_rd", 32'(pending_rd), 32'd0);
    check("write_count", 32'(n_writes - wr0), 32'(r != 0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending_valid"}, 32'(pending_valid), 32'd0);
    check({tag, "_pending_rd"}, 32'(pending_rd), 32'd0);
    check({tag, "_rd1"}, 32'(rd1), 32'd0);
    check({tag, "_we"}, 32'(rd1_write_enable), 32'd0);
    check({tag, "_data"}, 32'(rd1_write_data), 32'd0);
  endtask

  initial begin
    int wr0;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [AW-1:0] rr;

    vecs.push_back({2'b00, 16'd100,   16'd7,     4'd3,  16'd14});
    vecs.push_back({2'b10, 16'd100,   16'd7,     4'd7,  16'd2});
    vecs.push_back({2'b11, 16'hFFF9,  16'd2,     4'd5,  16'hFFFF});
    vecs.push_back({2'b01, 16'hFFF9,  16'd2,     4'd5,  16'hFFFD});
    vecs.push_back({2'b00, 16'd5,     16'd0,     4'd1,  16'hFFFF});
    vecs.push_back({2'b10, 16'd5,     16'd0,     4'd2,  16'h0005});
    vecs.push_back({2'b01, 16'h8000,  16'd0,     4'd9,  16'hFFFF});
    vecs.push_back({2'b11, 16'h8000,  16'd0,     4'd10, 16'h8000});
    vecs.push_back({2'b01, 16'h8000,  16'hFFFF,  4'd11, 16'h8000});
    vecs.push_back({2'b11, 16'h8000,  16'hFFFF,  4'd12, 16'h0000});
    vecs.push_back({2'b01, 16'h0007,  16'hFFFE,  4'd13, 16'hFFFD});
    vecs.push_back({2'b11, 16'h0007,  16'hFFFE,  4'd14, 16'h0001});
    vecs.push_back({2'b01, 16'hFFF9,  16'hFFFE,  4'd15, 16'h0003});
    vecs.push_back({2'b11, 16'hFFF9,  16'hFFFE,  4'd1,  16'hFFFF});
    vecs.push_back({2'b00, 16'hFFFF,  16'h0001,  4'd2,  16'hFFFF});
    vecs.push_back({2'b00, 16'hFFFF,  16'hFFFF,  4'd4,  16'h0001});
    vecs.push_back({2'b10, 16'hFFFE,  16'hFFFF,  4'd6,  16'hFFFE});
    vecs.push_back({2'b00, 16'h0003,  16'h0005,  4'd8,  16'h0000});
    vecs.push_back({2'b10, 16'h1234,  16'h0010,  4'd9,  16'h0004});
    vecs.push_back({2'b00, 16'h1234,  16'h0010,  4'd10, 16'h0123});

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0; rd = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rr = 4'($urandom_range(1, 15));
      run_op(ro, ra, rb, rr, ref_op(ro, ra, rb), 0, 1'b0);
    end

    // start held high for the whole operation, then rd = 0
    run_op(2'b00, 16'd100, 16'd7, 4'd3, 16'd14, 0, 1'b1);
    run_op(2'b00, 16'd100, 16'd7, 4'd0, 16'd14, 0, 1'b0);

    // flush in CALC then an immediate restart; flush in FIX; flush in WB keeps its write
    run_op(2'b01, 16'hFFF9, 16'd2, 4'd4, 16'hFFFD, 5, 1'b0);
    run_op(2'b00, 16'd100, 16'd7, 4'd3, 16'd14, 0, 1'b0);
    run_op(2'b10, 16'd100, 16'd7, 4'd6, 16'd2, W + 1, 1'b0);
    run_op(2'b11, 16'hFFF9, 16'd2, 4'd7, 16'hFFFF, WB_CYCLE, 1'b0);

    // start and flush together must not launch anything
    op = 2'b00; dividend = 16'd9; divisor = 16'd3; rd = 4'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_with_flush_busy", 32'(busy), 32'd0);

    // reset in the middle of an operation
    wr0 = n_writes;
    op = 2'b00; dividend = 16'd100; divisor = 16'd7; rd = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WB_CYCLE + 2) @(negedge clk);
    check("no_write_after_reset", 32'(n_writes - wr0), 32'd0);
    check_all_zero("post_reset");
    run_op(2'b00, 16'd100, 16'd7, 4'd3, 16'd14, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
